// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared FSM state encoding and width helpers for the motion-estimation search engine
package me_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_CUR,
      ST_SCAN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // Index width that never collapses to zero for single-entry ranges.
   function automatic int clog2w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sad_vec_min.sv
// rtl/sad_vec_min.sv - combinational minimum and lowest-index argmin over one SAD vector
module sad_vec_min
   import me_pkg::*;
#(
   parameter int NUM_CAND = 32,
   parameter int SAD_W    = 16,
   localparam int COL_W   = clog2w(NUM_CAND)
) (
   input  logic [NUM_CAND*SAD_W-1:0] sad_vec,
   output logic [SAD_W-1:0]          min_sad,
   output logic [COL_W-1:0]          min_col
);

   // Strict less-than walking upward keeps the lowest column on ties.
   always_comb begin
      min_sad = sad_vec[SAD_W-1:0];
      min_col = '0;
      for (int c = 1; c < NUM_CAND; c++) begin
         if (sad_vec[c*SAD_W +: SAD_W] < min_sad) begin
            min_sad = sad_vec[c*SAD_W +: SAD_W];
            min_col = COL_W'(c);
         end
      end
   end

endmodule

// File: rtl/layer_search_engine.sv
// rtl/layer_search_engine.sv - full-search block matcher: loads the current block, streams reference rows,
// tracks the best SAD candidate with optional threshold early termination
module layer_search_engine
   import me_pkg::*;
#(
   parameter int NUM_CAND = 32,
   parameter int SAD_W    = 16,
   parameter int SR_V     = 32,
   parameter int BLK_H    = 8,
   parameter int ADDR_W   = 7
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          thr_en,
   input  logic [SAD_W-1:0]              thr,
   output logic                          in_curr_enable,
   output logic                          rd8R_en,
   output logic [ADDR_W-1:0]             rd_address,
   input  logic                          sad_valid,
   input  logic [NUM_CAND*SAD_W-1:0]     sad_vec,
   output logic                          busy,
   output logic                          done,
   output logic [clog2w(NUM_CAND)-1:0]   best_mvx,
   output logic [clog2w(SR_V)-1:0]       best_mvy,
   output logic [SAD_W-1:0]              best_sad,
   output logic                          early_term
);

   localparam int COL_W = clog2w(NUM_CAND);
   localparam int ROW_W = clog2w(SR_V);
   localparam int LD_W  = clog2w(BLK_H);
   localparam logic [LD_W-1:0]   LD_LAST   = LD_W'(BLK_H - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SR_V + BLK_H - 2);
   localparam logic [ADDR_W-1:0] ROW_LAG   = ADDR_W'(BLK_H - 1);

   state_t              state_q, state_d;
   logic [LD_W-1:0]     ld_q, ld_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   rcv_q, rcv_d;
   logic                thr_en_q, thr_en_d;
   logic [SAD_W-1:0]    thr_q, thr_d;
   logic                min_vld_q, min_vld_d;
   logic [SAD_W-1:0]    min_sad_q, min_sad_d;
   logic [COL_W-1:0]    min_col_q, min_col_d;
   logic [ROW_W-1:0]    min_row_q, min_row_d;
   logic [SAD_W-1:0]    best_sad_q, best_sad_d;
   logic [COL_W-1:0]    best_mvx_q, best_mvx_d;
   logic [ROW_W-1:0]    best_mvy_q, best_mvy_d;
   logic                early_q, early_d;

   logic [SAD_W-1:0]    vec_min_sad;
   logic [COL_W-1:0]    vec_min_col;
   logic [ADDR_W-1:0]   exp_cnt;
   logic                accept;
   logic                improve;
   logic                hit;

   sad_vec_min #(
      .NUM_CAND (NUM_CAND),
      .SAD_W    (SAD_W)
   ) u_sad_vec_min (
      .sad_vec  (sad_vec),
      .min_sad  (vec_min_sad),
      .min_col  (vec_min_col)
   );

   always_comb begin
      state_d    = state_q;
      ld_d       = ld_q;
      addr_d     = addr_q;
      rcv_d      = rcv_q;
      thr_en_d   = thr_en_q;
      thr_d      = thr_q;
      min_sad_d  = min_sad_q;
      min_col_d  = min_col_q;
      min_row_d  = min_row_q;
      best_sad_d = best_sad_q;
      best_mvx_d = best_mvx_q;
      best_mvy_d = best_mvy_q;
      early_d    = early_q;

      // Candidate rows whose BLK_H reference rows have all been read (addr_q counts issued reads).
      exp_cnt = (addr_q > ROW_LAG) ? (addr_q - ROW_LAG) : '0;
      accept  = sad_valid && ((state_q == ST_SCAN) || (state_q == ST_DRAIN)) && (rcv_q < exp_cnt);
      improve = min_vld_q && !early_q && (min_sad_q < best_sad_q);
      hit     = improve && thr_en_q && (min_sad_q < thr_q);

      min_vld_d = accept;
      if (accept) begin
         min_sad_d = vec_min_sad;
         min_col_d = vec_min_col;
         min_row_d = rcv_q[ROW_W-1:0];
         rcv_d     = rcv_q + ADDR_W'(1);
      end

      if (improve) begin
         best_sad_d = min_sad_q;
         best_mvx_d = min_col_q;
         best_mvy_d = min_row_q;
      end
      if (hit) begin
         early_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_LOAD_CUR;
               ld_d       = '0;
               addr_d     = '0;
               rcv_d      = '0;
               thr_en_d   = thr_en;
               thr_d      = thr;
               min_vld_d  = 1'b0;
               best_sad_d = '1;
               best_mvx_d = '0;
               best_mvy_d = '0;
               early_d    = 1'b0;
            end
         end
         ST_LOAD_CUR: begin
            ld_d = ld_q + LD_W'(1);
            if (ld_q == LD_LAST) begin
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            addr_d = addr_q + ADDR_W'(1);
            if (hit || (addr_q == ADDR_LAST)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (rcv_q == exp_cnt) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ld_q       <= '0;
         addr_q     <= '0;
         rcv_q      <= '0;
         thr_en_q   <= 1'b0;
         thr_q      <= '0;
         min_vld_q  <= 1'b0;
         min_sad_q  <= '0;
         min_col_q  <= '0;
         min_row_q  <= '0;
         best_sad_q <= '1;
         best_mvx_q <= '0;
         best_mvy_q <= '0;
         early_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ld_q       <= ld_d;
         addr_q     <= addr_d;
         rcv_q      <= rcv_d;
         thr_en_q   <= thr_en_d;
         thr_q      <= thr_d;
         min_vld_q  <= min_vld_d;
         min_sad_q  <= min_sad_d;
         min_col_q  <= min_col_d;
         min_row_q  <= min_row_d;
         best_sad_q <= best_sad_d;
         best_mvx_q <= best_mvx_d;
         best_mvy_q <= best_mvy_d;
         early_q    <= early_d;
      end
   end

   assign in_curr_enable = (state_q == ST_LOAD_CUR);
   assign rd8R_en        = (state_q == ST_SCAN);
   assign rd_address     = (state_q == ST_SCAN) ? addr_q : '0;
   assign busy           = (state_q == ST_LOAD_CUR) || (state_q == ST_SCAN) || (state_q == ST_DRAIN);
   assign done           = (state_q == ST_DONE);
   assign best_mvx       = best_mvx_q;
   assign best_mvy       = best_mvy_q;
   assign best_sad       = best_sad_q;
   assign early_term     = early_q;

endmodule

// File: tb/tb_layer_search_engine.sv
// tb/tb_layer_search_engine.sv - self-checking bench for layer_search_engine with a row-order reference model
module tb_layer_search_engine;

   localparam int NC   = 4;
   localparam int SW   = 16;
   localparam int SRV  = 4;
   localparam int BH   = 2;
   localparam int AW   = 7;
   localparam int FULL = SRV + BH - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              thr_en;
   logic [SW-1:0]     thr;
   logic              in_curr_enable;
   logic              rd8R_en;
   logic [AW-1:0]     rd_address;
   logic              sad_valid;
   logic [NC*SW-1:0]  sad_vec;
   logic              busy;
   logic              done;
   logic [1:0]        best_mvx;
   logic [1:0]        best_mvy;
   logic [SW-1:0]     best_sad;
   logic              early_term;

   logic [SW-1:0]     sads [SRV][NC];
   int                checks = 0;
   int                errors = 0;

   layer_search_engine #(
      .NUM_CAND (NC),
      .SAD_W    (SW),
      .SR_V     (SRV),
      .BLK_H    (BH),
      .ADDR_W   (AW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .thr_en         (thr_en),
      .thr            (thr),
      .in_curr_enable (in_curr_enable),
      .rd8R_en        (rd8R_en),
      .rd_address     (rd_address),
      .sad_valid      (sad_valid),
      .sad_vec        (sad_vec),
      .busy           (busy),
      .done           (done),
      .best_mvx       (best_mvx),
      .best_mvy       (best_mvy),
      .best_sad       (best_sad),
      .early_term     (early_term)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NC*SW-1:0] pack_row(input int r);
      logic [NC*SW-1:0] v;
      v = '0;
      for (int c = 0; c < NC; c++) v[c*SW +: SW] = sads[r][c];
      return v;
   endfunction

   task automatic fill_rand(input int lo, input int hi);
      for (int r = 0; r < SRV; r++)
         for (int c = 0; c < NC; c++)
            sads[r][c] = SW'($urandom_range(lo, hi));
   endtask

   // Rows visited in order; within a row columns low to high; strict improvement only;
   // once the running best drops under the threshold the remaining rows are ignored.
   task automatic model(input logic te, input logic [SW-1:0] th,
                        output logic [SW-1:0] b, output int bx, output int by, output logic et);
      b = '1; bx = 0; by = 0; et = 1'b0;
      for (int r = 0; r < SRV; r++) begin
         if (!et) begin
            for (int c = 0; c < NC; c++) begin
               if (sads[r][c] < b) begin
                  b = sads[r][c]; bx = c; by = r;
               end
            end
            if (te && (b < th)) et = 1'b1;
         end
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_curr"}, 32'(in_curr_enable), 32'd0);
      chk({tag, "_rd_en"},   32'(rd8R_en),        32'd0);
      chk({tag, "_rd_addr"}, 32'(rd_address),     32'd0);
      chk({tag, "_busy"},    32'(busy),           32'd0);
      chk({tag, "_done"},    32'(done),           32'd0);
      chk({tag, "_mvx"},     32'(best_mvx),       32'd0);
      chk({tag, "_mvy"},     32'(best_mvy),       32'd0);
      chk({tag, "_sad"},     32'(best_sad),       32'hffff);
      chk({tag, "_early"},   32'(early_term),     32'd0);
   endtask

   // Called at posedge+1 of an IDLE cycle; acts as the SAD tree and returns after the cycle following done.
   task automatic run_search(input logic te, input logic [SW-1:0] th, input int lat_max,
                             input bit spam, input string tag, output int issued);
      logic [SW-1:0] m_sad;
      int            m_x, m_y;
      logic          m_et;
      int            q_row[$];
      int            q_rdy[$];
      int            loads, ld_bad, addr_bad, busy_bad;
      bit            got_done;

      model(te, th, m_sad, m_x, m_y, m_et);
      issued = 0; loads = 0; ld_bad = 0; addr_bad = 0; busy_bad = 0; got_done = 1'b0;
      thr_en = te; thr = th; start = 1'b1; sad_valid = 1'b0; sad_vec = '0;

      for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
         @(posedge clk); #1;
         start     = spam ? 1'($urandom_range(0, 1)) : 1'b0;
         thr_en    = 1'($urandom_range(0, 1));
         thr       = SW'($urandom);
         sad_valid = 1'b0;
         sad_vec   = '0;
         if (done) got_done = 1'b1;
         else if (!busy) busy_bad++;
         if (in_curr_enable) loads++;
         if (rd8R_en) begin
            if (loads != BH) ld_bad++;
            if (int'(rd_address) != issued) addr_bad++;
            issued++;
            if (issued >= BH) begin
               q_row.push_back(issued - BH);
               q_rdy.push_back(cyc + $urandom_range(1, lat_max));
            end
         end
         if (q_row.size() > 0) begin
            if (q_rdy[0] <= cyc) begin
               sad_valid = 1'b1;
               sad_vec   = pack_row(q_row.pop_front());
               void'(q_rdy.pop_front());
            end
         end else begin
            // Nothing outstanding: any vector now lies beyond the expected count and must be ignored.
            sad_valid = 1'($urandom_range(0, 1));
         end
      end

      chk({tag, "_done_seen"},  32'(got_done), 32'd1);
      chk({tag, "_busy_gaps"},  32'(busy_bad), 32'd0);
      chk({tag, "_load_cnt"},   32'(loads),    32'(BH));
      chk({tag, "_load_order"}, 32'(ld_bad),   32'd0);
      chk({tag, "_addr_seq"},   32'(addr_bad), 32'd0);
      if (!m_et) chk({tag, "_reads"}, 32'(issued), 32'(FULL));
      chk({tag, "_sad"},   32'(best_sad),   32'(m_sad));
      chk({tag, "_mvx"},   32'(best_mvx),   32'(m_x));
      chk({tag, "_mvy"},   32'(best_mvy),   32'(m_y));
      chk({tag, "_early"}, 32'(early_term), 32'(m_et));

      @(posedge clk); #1;
      start = 1'b0; sad_valid = 1'b0;
      chk({tag, "_done_once"}, 32'(done),           32'd0);
      chk({tag, "_idle_busy"}, 32'(busy),           32'd0);
      chk({tag, "_idle_load"}, 32'(in_curr_enable), 32'd0);
      chk({tag, "_hold_sad"},  32'(best_sad),       32'(m_sad));
   endtask

   initial begin
      int            issued;
      bit            seen;
      logic [SW-1:0] h_sad;
      logic [1:0]    h_x, h_y;
      logic          h_et;

      rst = 1'b1; start = 1'b0; thr_en = 1'b0; thr = '0; sad_valid = 1'b0; sad_vec = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst = 1'b0;

      // Unique minimum 5 at row 2, column 3.
      fill_rand(6, 200);
      sads[2][3] = 16'd5;
      run_search(1'b0, 16'd0, 1, 1'b0, "uniq_min", issued);

      // Equal minima: the earlier row wins; start spammed while busy and at done.
      fill_rand(8, 200);
      sads[1][2] = 16'd7;
      sads[3][0] = 16'd7;
      run_search(1'b0, 16'd0, 2, 1'b1, "tie_min", issued);

      // Threshold hit on row 0; a smaller later SAD must be discarded.
      fill_rand(11, 200);
      sads[0][0] = 16'd20; sads[0][1] = 16'd4; sads[0][2] = 16'd9; sads[0][3] = 16'd30;
      sads[2][1] = 16'd1;
      run_search(1'b1, 16'd10, 1, 1'b0, "thr_stop", issued);
      chk("thr_stop_reads_cut", 32'(issued < FULL), 32'd1);

      // Idle: stray valids (all-zero vectors) and nothing else must leave results untouched.
      h_sad = best_sad; h_x = best_mvx; h_y = best_mvy; h_et = early_term;
      for (int i = 0; i < 4; i++) begin
         sad_valid = 1'b1; sad_vec = '0;
         @(posedge clk); #1;
      end
      sad_valid = 1'b0;
      chk("idle_busy",  32'(busy),       32'd0);
      chk("idle_sad",   32'(best_sad),   32'(h_sad));
      chk("idle_mvx",   32'(best_mvx),   32'(h_x));
      chk("idle_mvy",   32'(best_mvy),   32'(h_y));
      chk("idle_early", 32'(early_term), 32'(h_et));

      // Reset in the middle of SCAN.
      start = 1'b1; thr_en = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (rd8R_en) seen = 1'b1;
      end
      chk("midrst_scan_seen", 32'(seen), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset_vals("midrst");
      rst = 1'b0;
      @(posedge clk); #1;

      fill_rand(0, 60);
      run_search(1'b0, 16'd0, 3, 1'b0, "post_rst", issued);

      // Randomized back-to-back searches.
      for (int n = 0; n < 10; n++) begin
         fill_rand(0, 40);
         run_search(1'($urandom_range(0, 1)), SW'($urandom_range(0, 40)),
                    $urandom_range(1, 3), 1'($urandom_range(0, 1)), $sformatf("rand%0d", n), issued);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
